// File: rtl/ram_stream_loader.sv
// rtl/ram_stream_loader.sv - stream-to-RAM bus master with optional per-byte readback verify
module ram_stream_loader #(
    parameter int DEPTH    = 128,
    parameter int RAM_BASE = 0,
    parameter bit VERIFY   = 1'b1
) (
    input  logic       CLK,
    input  logic       RESET,
    inout  wire  [7:0] BUS_DATA,
    output logic [7:0] BUS_ADDR,
    output logic       BUS_WE,
    output logic       BUS_REQ,
    input  logic       BUS_GNT,
    input  logic       START,
    input  logic [6:0] BASE_OFS,
    input  logic [7:0] LEN,
    input  logic [7:0] S_DATA,
    input  logic       S_VALID,
    output logic       S_READY,
    output logic       BUSY,
    output logic       DONE,
    output logic       ERR
);

    typedef enum logic [2:0] {
        ST_IDLE, ST_REQ, ST_FETCH, ST_WR1, ST_WR2, ST_RD, ST_NEXT, ST_FINISH
    } state_t;

    state_t     r_state;
    logic [6:0] r_ofs;
    logic [7:0] r_cnt;
    logic [7:0] r_hold;
    logic [7:0] r_addr;
    logic       r_we;
    logic       r_req;
    logic       r_ready;
    logic       r_busy;
    logic       r_done;
    logic       r_err;

    logic       w_active;
    logic       w_gnt_lost;

    assign w_active   = (r_state == ST_FETCH) || (r_state == ST_WR1) || (r_state == ST_WR2) ||
                        (r_state == ST_RD)    || (r_state == ST_NEXT);
    assign w_gnt_lost = w_active && !BUS_GNT;

    // Bus drivers are gated by the grant combinationally so a lost grant releases the bus at once.
    assign BUS_WE   = r_we && BUS_GNT;
    assign BUS_ADDR = (r_req && BUS_GNT) ? r_addr : 8'h00;
    assign BUS_DATA = BUS_WE ? r_hold : 8'hzz;
    assign BUS_REQ  = r_req;
    assign S_READY  = r_ready && BUS_GNT;
    assign BUSY     = r_busy;
    assign DONE     = r_done;
    assign ERR      = r_err;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state <= ST_IDLE;
            r_ofs   <= 7'd0;
            r_cnt   <= 8'd0;
            r_hold  <= 8'd0;
            r_addr  <= 8'd0;
            r_we    <= 1'b0;
            r_req   <= 1'b0;
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_gnt_lost) begin
                r_err   <= 1'b1;
                r_we    <= 1'b0;
                r_ready <= 1'b0;
                r_req   <= 1'b0;
                r_busy  <= 1'b0;
                r_addr  <= 8'd0;
                r_done  <= 1'b1;
                r_state <= ST_FINISH;
            end else begin
                case (r_state)
                    ST_IDLE, ST_FINISH: begin
                        r_state <= ST_IDLE;
                        if (START) begin
                            r_err <= 1'b0;
                            if (LEN != 8'd0) begin
                                r_ofs   <= BASE_OFS;
                                r_cnt   <= LEN;
                                r_busy  <= 1'b1;
                                r_req   <= 1'b1;
                                r_state <= ST_REQ;
                            end else begin
                                r_done  <= 1'b1;
                                r_state <= ST_FINISH;
                            end
                        end
                    end
                    ST_REQ: begin
                        if (BUS_GNT) begin
                            r_ready <= 1'b1;
                            r_state <= ST_FETCH;
                        end
                    end
                    ST_FETCH: begin
                        if (S_VALID) begin
                            r_hold  <= S_DATA;
                            r_ready <= 1'b0;
                            r_addr  <= 8'(RAM_BASE) + {1'b0, r_ofs};
                            r_we    <= 1'b1;
                            r_state <= ST_WR1;
                        end
                    end
                    ST_WR1: r_state <= ST_WR2;
                    ST_WR2: begin
                        // The RAM registers its write enable, so the write commits at the end of this cycle.
                        r_we    <= 1'b0;
                        r_state <= VERIFY ? ST_RD : ST_NEXT;
                    end
                    ST_RD: begin
                        if (BUS_DATA != r_hold) begin
                            r_err <= 1'b1;
                        end
                        r_state <= ST_NEXT;
                    end
                    ST_NEXT: begin
                        r_ofs <= (r_ofs == 7'(DEPTH - 1)) ? 7'd0 : r_ofs + 7'd1;
                        r_cnt <= r_cnt - 8'd1;
                        if (r_cnt == 8'd1) begin
                            r_req   <= 1'b0;
                            r_busy  <= 1'b0;
                            r_addr  <= 8'd0;
                            r_done  <= 1'b1;
                            r_state <= ST_FINISH;
                        end else begin
                            r_ready <= 1'b1;
                            r_state <= ST_FETCH;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ram_stream_loader.sv
// tb/tb_ram_stream_loader.sv - directed bench with RAM model and write scoreboard for ram_stream_loader
module tb_ram_stream_loader;

    logic       clk = 1'b0;
    logic       rst_n;
    wire  [7:0] bus_data;
    logic [7:0] bus_addr;
    logic       bus_we;
    logic       bus_req;
    logic       bus_gnt;
    logic       start;
    logic [6:0] base_ofs;
    logic [7:0] len;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_ready;
    logic       busy;
    logic       done;
    logic       err;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } sb_t;
    sb_t sb[$];
    sb_t sb_e;

    logic [7:0] mem [0:127] = '{default: 8'h00};
    logic [7:0] src [0:127];
    logic [7:0] bp  [0:127];
    logic       ram_we_q = 1'b0;
    logic       corrupt = 1'b0;
    logic [7:0] corrupt_addr = 8'h00;
    int         commits = 0;
    int         done_cnt = 0;
    int         we_len = 0;
    bit         width_chk = 1'b1;

    ram_stream_loader dut (
        .CLK(clk), .RESET(rst_n), .BUS_DATA(bus_data), .BUS_ADDR(bus_addr), .BUS_WE(bus_we),
        .BUS_REQ(bus_req), .BUS_GNT(bus_gnt), .START(start), .BASE_OFS(base_ofs), .LEN(len),
        .S_DATA(s_data), .S_VALID(s_valid), .S_READY(s_ready), .BUSY(busy), .DONE(done), .ERR(err)
    );

    genvar g;
    generate
        for (g = 0; g < 8; g++) begin : g_pu
            pullup (bus_data[g]);
        end
    endgenerate

    assign bus_data = (bus_req && bus_gnt && !bus_we) ?
                      ((corrupt && bus_addr == corrupt_addr) ? 8'hFF : mem[bus_addr[6:0]]) : 8'hzz;

    initial forever #5 clk = ~clk;

    initial begin
        #800000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // RAM model (commits on the second edge of a held write) plus scoreboard and bus invariants.
    always @(posedge clk) begin
        ram_we_q <= bus_we;
        if (done) done_cnt <= done_cnt + 1;
        if (s_ready) chk("ready_excl_we", bus_we, 1'b0);
        if (bus_we) begin
            we_len <= we_len + 1;
        end else if (we_len != 0) begin
            if (width_chk) chk("we_width", we_len, 2);
            we_len <= 0;
        end
        if (bus_we && ram_we_q) begin
            mem[bus_addr[6:0]] <= bus_data;
            commits <= commits + 1;
            chk("sb_nonempty", sb.size() > 0, 1'b1);
            if (sb.size() > 0) begin
                sb_e = sb.pop_front();
                chk("sb_addr", bus_addr, sb_e.addr);
                chk("sb_data", bus_data, sb_e.data);
            end
        end
    end

    task automatic load(input logic [6:0] ofs, input int n, input bit rnd, input int abort_after);
        int  idx = 0;
        int  base_commits;
        int  base_done;
        bit  aborted = 1'b0;
        int  w;
        @(negedge clk);
        base_commits = commits;
        base_done = done_cnt;
        start = 1'b1;
        base_ofs = ofs;
        len = 8'(n);
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 40 * n + 40 && idx < n; k++) begin
            if (abort_after != 0 && commits == base_commits + abort_after && bus_we) begin
                bus_gnt = 1'b0;
                s_valid = 1'b0;
                #1;
                chk("abort_we", bus_we, 1'b0);
                chk("abort_addr", bus_addr, 8'h00);
                chk("abort_data", bus_data, 8'hFF);
                aborted = 1'b1;
                break;
            end
            s_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            s_data = src[idx];
            if (s_valid && s_ready) begin
                sb.push_back({8'((int'(ofs) + idx) % 128), src[idx]});
                idx++;
            end
            @(negedge clk);
        end
        s_valid = 1'b0;
        if (!aborted) chk("send_all", idx, n);
        for (w = 0; w < 50 && !done; w++) @(negedge clk);
        chk("done_seen", done, 1'b1);
        @(negedge clk);
        chk("done_pulse", done, 1'b0);
        chk("done_once", done_cnt - base_done, 1);
        chk("req_released", bus_req, 1'b0);
    endtask

    initial begin
        int cyc;
        bit acc;
        rst_n = 1'b0;
        bus_gnt = 1'b1;
        start = 1'b0;
        base_ofs = 7'd0;
        len = 8'd0;
        s_data = 8'd0;
        s_valid = 1'b0;
        for (int i = 0; i < 128; i++) bp[i] = 8'($urandom);
        bp[8'h52] = 8'hC5;
        bp[8'h40] = 8'h96;

        repeat (3) @(negedge clk);
        chk("rst_req", bus_req, 1'b0);
        chk("rst_we", bus_we, 1'b0);
        chk("rst_addr", bus_addr, 8'h00);
        chk("rst_data_z", bus_data, 8'hFF);
        chk("rst_ready", s_ready, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single byte, grant high, data already valid: START to DONE is 7 cycles.
        s_data = 8'h77;
        s_valid = 1'b1;
        sb.push_back({8'h05, 8'h77});
        start = 1'b1;
        base_ofs = 7'h05;
        len = 8'd1;
        acc = 1'b0;
        for (cyc = 1; cyc <= 20; cyc++) begin
            @(negedge clk);
            if (cyc == 1) start = 1'b0;
            if (acc) s_valid = 1'b0;
            if (s_ready && s_valid) acc = 1'b1;
            if (done) break;
        end
        chk("lat_start_done", cyc, 7);
        @(negedge clk);
        s_valid = 1'b0;
        chk("lat_mem", mem[5], 8'h77);
        chk("lat_err", err, 1'b0);

        src[0] = 8'hA1; src[1] = 8'hB2; src[2] = 8'hC3; src[3] = 8'hD4;
        load(7'h10, 4, 1'b0, 0);
        chk("basic_m10", mem[8'h10], 8'hA1);
        chk("basic_m11", mem[8'h11], 8'hB2);
        chk("basic_m12", mem[8'h12], 8'hC3);
        chk("basic_m13", mem[8'h13], 8'hD4);
        chk("basic_err", err, 1'b0);

        src[0] = 8'h11; src[1] = 8'h22; src[2] = 8'h33;
        load(7'h7E, 3, 1'b0, 0);
        chk("wrap_m7e", mem[8'h7E], 8'h11);
        chk("wrap_m7f", mem[8'h7F], 8'h22);
        chk("wrap_m00", mem[8'h00], 8'h33);

        src[0] = 8'h01; src[1] = 8'h5A; src[2] = 8'h03;
        corrupt_addr = 8'h21;
        corrupt = 1'b1;
        load(7'h20, 3, 1'b0, 0);
        corrupt = 1'b0;
        chk("verr_err", err, 1'b1);
        chk("verr_mem", mem[8'h21], 8'h5A);
        repeat (3) @(negedge clk);
        chk("verr_sticky", err, 1'b1);
        start = 1'b1;
        len = 8'd0;
        @(negedge clk);
        start = 1'b0;
        chk("len0_done", done, 1'b1);
        chk("len0_err_clr", err, 1'b0);
        chk("len0_req", bus_req, 1'b0);
        @(negedge clk);
        chk("len0_done_end", done, 1'b0);
        chk("len0_req2", bus_req, 1'b0);

        for (int i = 0; i < 128; i++) src[i] = bp[i];
        load(7'h00, 128, 1'b1, 0);
        for (int i = 0; i < 128; i++) chk("bp_mem", mem[i], bp[i]);
        chk("bp_err", err, 1'b0);

        width_chk = 1'b0;
        src[0] = 8'h61; src[1] = 8'h62; src[2] = 8'h63; src[3] = 8'h64; src[4] = 8'h65;
        load(7'h50, 5, 1'b0, 2);
        chk("gl_err", err, 1'b1);
        chk("gl_m50", mem[8'h50], 8'h61);
        chk("gl_m51", mem[8'h51], 8'h62);
        chk("gl_m52", mem[8'h52], 8'hC5);
        chk("gl_pending", sb.size(), 1);
        sb.delete();
        bus_gnt = 1'b1;
        repeat (2) @(negedge clk);

        s_data = 8'h3C;
        s_valid = 1'b1;
        start = 1'b1;
        base_ofs = 7'h40;
        len = 8'd2;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 20 && !bus_we; k++) @(negedge clk);
        s_valid = 1'b0;
        @(negedge clk);
        chk("rst_in_wr2", bus_we, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_req", bus_req, 1'b0);
        chk("mid_rst_we", bus_we, 1'b0);
        chk("mid_rst_data_z", bus_data, 8'hFF);
        chk("mid_rst_busy", busy, 1'b0);
        @(negedge clk);
        chk("mid_rst_mem", mem[8'h40], 8'h96);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_rst_busy", busy, 1'b0);
        sb.delete();
        width_chk = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ram_stream_loader.md
Name: ram_stream_loader

Overview:
- Bus master that sits directly upstream of the 128 x 8 bus RAM.
- Accepts a byte stream over a valid/ready handshake and writes the bytes to consecutive RAM addresses over the shared 8-bit BUS_DATA/BUS_ADDR/BUS_WE bus.
- Reads each byte back to verify it.
- Used to preload or refresh RAM contents (tables, sprite data) without processor involvement. It requests the bus from the arbiter and releases it when finished.

Parameters:
- DEPTH, 128, size of the target RAM window in bytes; the address wraps modulo DEPTH relative to RAM_BASE.
- RAM_BASE, 0, bus address of RAM location 0.
- VERIFY, 1, 1 = read back and compare every byte; 0 = skip the readback.

Ports:
- CLK  in  1  system clock; all state changes on its rising edge.
- RESET  in  1  asynchronous, active-low reset.
- BUS_DATA  inout  8  shared data bus; driven only in the write states, otherwise 8'hZZ.
- BUS_ADDR  out  8  bus address; 8'h00 when not granted.
- BUS_WE  out  1  bus write enable; 0 when not granted.
- BUS_REQ  out  1  bus request to the arbiter.
- BUS_GNT  in  1  bus grant from the arbiter.
- START  in  1  one-cycle pulse; latches BASE_OFS and LEN; ignored while BUSY.
- BASE_OFS  in  7  first RAM offset (0..DEPTH-1).
- LEN  in  8  byte count; 0 means no transfer.
- S_DATA  in  8  stream byte.
- S_VALID  in  1  S_DATA is valid.
- S_READY  out  1  the block accepts S_DATA this cycle.
- BUSY  out  1  transfer in progress.
- DONE  out  1  one-cycle pulse at the end of a transfer.
- ERR  out  1  sticky error flag; cleared on START.

Behaviour:
- Reset (RESET=0, asynchronous): state IDLE; BUS_REQ=0, BUS_WE=0, BUS_ADDR=0, BUS_DATA=Z, S_READY=0, BUSY=0, DONE=0, ERR=0; counters cleared. Reset mid-transfer abandons it and releases the bus immediately; partially written RAM contents are not restored.
- IDLE:
  - START with LEN≠0 → latch offset and count, clear ERR, BUSY=1 → REQ.
  - START with LEN=0 → DONE pulse next cycle, bus never requested.
- REQ: BUS_REQ=1 and held high until FINISH. On BUS_GNT=1 → FETCH.
- FETCH: S_READY=1. On S_VALID=1, S_DATA is latched into a holding register → WR1. S_READY is high only in FETCH; the handshake completes when S_VALID & S_READY at a clock edge.
- WR1: drive BUS_ADDR=RAM_BASE+ofs, BUS_DATA=hold, BUS_WE=1 → WR2.
- WR2: hold identical address, data and BUS_WE=1 for a second cycle. The RAM registers its write-enable, so it commits on the second edge.
  - → RD when VERIFY=1.
  - → NEXT when VERIFY=0.
- RD: BUS_WE=0, BUS_DATA=Z, BUS_ADDR unchanged. The RAM drives the bus combinationally. At the edge leaving RD, compare BUS_DATA with hold; a mismatch sets ERR. → NEXT.
- NEXT:
  - ofs = (ofs+1) mod DEPTH, so 127 wraps to 0; count = count-1.
  - count reaching 0 → FINISH; otherwise → FETCH.
  - BUS_WE=0 and BUS_DATA=Z in this cycle, giving one turnaround cycle between bus beats.
- FINISH: BUS_REQ=0, BUSY=0, DONE=1 for exactly one cycle → IDLE.
- Grant loss: BUS_GNT falling in any of FETCH/WR1/WR2/RD/NEXT sets ERR, drops all bus drivers within the same cycle (combinational gating on BUS_GNT), → FINISH. The transfer is aborted, not resumed.
- Per-byte latency: 4 cycles (FETCH with S_VALID already high, WR1, WR2, RD/NEXT), 5 with VERIFY=1. Minimum transfer of 1 byte, grant already high: START to DONE = 7 cycles with VERIFY=1.
- BUS_DATA is never driven while BUS_WE=0; BUS_ADDR and BUS_WE are 0 whenever BUS_GNT=0.
- Simultaneous events:
  - START while BUSY is ignored.
  - S_VALID outside FETCH is ignored, with no data loss because S_READY=0.

Test Plan:
- Reset/idle: RESET low mid-WR2 → next sample BUS_REQ=0, BUS_WE=0, BUS_DATA=Z, BUSY=0; RAM location untouched, or written at most once.
- Basic load: BASE_OFS=0x10, LEN=4, GNT tied high, stream 0xA1,0xB2,0xC3,0xD4 → RAM[0x10..0x13] holds those values, each BUS_WE pulse exactly 2 cycles, DONE once, ERR=0.
- Wrap: BASE_OFS=0x7E, LEN=3, bytes 0x11,0x22,0x33 → RAM[0x7E]=0x11, RAM[0x7F]=0x22, RAM[0x00]=0x33.
- Backpressure: S_VALID toggling randomly → no byte dropped or duplicated; S_READY high only in FETCH; 128-byte load matches the source stream.
- Verify error: bench forces BUS_DATA=0xFF during one RD while 0x5A was written → ERR=1 sticky; transfer completes with DONE; the next START clears ERR.
- Grant loss and LEN=0: GNT dropped after byte 2 of 5 → ERR=1, drivers released the same cycle, DONE, only 2 bytes written. Separately, START with LEN=0 → DONE after 1 cycle and BUS_REQ never asserted.
